button_msg_scheduler: RTL and testbench
=======================================

// Module: button_msg_scheduler
// PURPOSE
//   Round-robin scheduler between NUM_BTN debounced push-buttons and the single UART transmitter.
//   - Sits downstream of the per-button debounce instances and upstream of the UART TX byte interface.
//   - Each debounced press (rising edge) queues one 4-byte ASCII message: 'B', '0'+index, CR (0x0D), LF (0x0A).
//   - Queued messages are serialised to the TX over a valid/ready handshake, one whole message at a time.
// PARAMETERS
//   NUM_BTN     4   number of button requesters, legal range 1..10 (index fits one ASCII digit)
//   CNT_W       8   width of the saturating overrun counter
// PORTS
//   clk          in   1        system clock, 12 MHz
//   rst_n        in   1        asynchronous, active-low reset
//   btn_db       in   NUM_BTN  debounced button levels, active-high, synchronous to clk
//   tx_ready     in   1        UART TX can accept a byte this cycle
//   tx_valid     out  1        tx_data holds a valid byte
//   tx_data      out  8        byte offered to UART TX
//   busy         out  1        a message is in flight (state SEND)
//   pending      out  NUM_BTN  per-button queued-request flags
//   overrun_cnt  out  CNT_W    presses lost because that button already had a message pending
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - All outputs are 0.
//   - btn_q <= 0, last_grant <= NUM_BTN-1 (so button 0 wins first), byte_idx <= 0, state <= IDLE.
//   Edge detect:
//   - btn_q registers btn_db; rise[i] = btn_db[i] & ~btn_q[i]. Falling edges are ignored.
//   - If rise[i] and pending[i]=0: pending[i] <= 1.
//   - If rise[i] and pending[i]=1 (and not being granted this cycle): overrun_cnt += 1, saturating at all-ones.
//   - Several rises on the same edge: all are set or counted; overrun_cnt adds once per overrunning button.
//   - Grant and rise on the same button, same cycle: set wins. pending stays 1, no overrun is counted.
//   State machine (states IDLE, SEND):
//   - IDLE: if any pending bit is set, pick the first set bit scanning last_grant+1, +2, ... (wrapping).
//     Then: pending[g] <= 0, last_grant <= g, byte_idx <= 0, tx_valid <= 1, tx_data <= 'B' (0x42), state <= SEND.
//     If no pending bit is set, stay in IDLE with tx_valid = 0.
//   - SEND: a byte is accepted on a clock edge where tx_valid & tx_ready.
//     - On accept with byte_idx < 3: byte_idx += 1, tx_data <= next byte; tx_valid stays 1 with no gap.
//     - On accept with byte_idx = 3: tx_valid <= 0, state <= IDLE.
//     - Without accept: tx_valid and tx_data are held stable. tx_valid never drops before acceptance.
//   - busy = (state == SEND).
//   - Minimum IDLE dwell is one cycle between messages, so back-to-back messages have a 1-cycle tx_valid gap.
//   Latency:
//   - btn_db rises before edge E0; pending set at E0.
//   - If IDLE, tx_valid=1 with 'B' after E1 (2 cycles).
//   - Message occupies at least 4 accepting cycles.
//   Fairness and overrun:
//   - A button granted while others are pending is served again only after every other pending button has been served.
//   - A press during that button's own message re-queues it (pending is already cleared at grant), with no overrun.
//   Reset mid-message: the message is abandoned, tx_valid drops asynchronously, and all queued requests are discarded.
//   Digit byte: 8'h30 + g, where g has the width of the grant index.
// TESTING
//   1. Single press: rst_n released, tx_ready=1, btn_db[2] 0->1.
//      -> tx_valid rises 2 cycles later; bytes 42,32,0D,0A on 4 consecutive cycles; then IDLE, busy=0.
//   2. Backpressure: during test 1, tx_ready=0 for 5 cycles at byte 2.
//      -> tx_data holds 0D with tx_valid=1 throughout; no byte is skipped or duplicated.
//   3. Simultaneous press: btn_db[0], [1] and [3] rise on the same edge.
//      -> messages in order B0, B1, B3; 1 idle cycle between each; overrun_cnt=0.
//   4. Overrun: btn_db[1] pulses 3 times while button 0 holds the TX (tx_ready=0).
//      -> pending[1]=1, overrun_cnt=2; exactly one B1 message is sent afterwards.
//   5. Re-press own button: btn_db[0] re-rises during its own message.
//      -> a second B0 follows, overrun_cnt unchanged.
//      Saturation: force 300 overruns with CNT_W=8 -> overrun_cnt=255.
//   6. Reset mid-message: rst_n=0 after byte 1 accepted.
//      -> tx_valid=0 immediately, pending=0.
//      After release with no input change, nothing is sent.

Source files
------------

// File: rtl/button_msg_scheduler.sv
// Round-robin scheduler that turns debounced button presses into "B<n>\r\n" messages
// and streams them, one whole message at a time, to a UART TX over valid/ready.
module button_msg_scheduler #(
  parameter int NUM_BTN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_db,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [NUM_BTN-1:0] pending,
  output logic [CNT_W-1:0]   overrun_cnt
);

  localparam int GW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_next;
  logic [NUM_BTN-1:0] btn_q, rise, grant_vec, pending_next;
  logic [GW-1:0]      last_grant, last_grant_next, grant_idx;
  logic               grant_found;
  logic [1:0]         byte_idx, byte_idx_next;
  logic               tx_valid_next, accept;
  logic [7:0]         tx_data_next;
  logic [CNT_W-1:0]   overrun_next;

  function automatic logic [7:0] msg_byte(input logic [1:0] idx, input logic [GW-1:0] g);
    case (idx)
      2'd0:    return 8'h42;
      2'd1:    return 8'h30 + 8'(g);
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign rise   = btn_db & ~btn_q;
  assign accept = tx_valid & tx_ready;
  assign busy   = (state == SEND);

  // Scan from the button after the last one served so nobody is starved.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      cand = (int'(last_grant) + k) % NUM_BTN;
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_next      = state;
    byte_idx_next   = byte_idx;
    last_grant_next = last_grant;
    tx_valid_next   = tx_valid;
    tx_data_next    = tx_data;
    grant_vec       = '0;
    case (state)
      IDLE: begin
        tx_valid_next = 1'b0;
        if (grant_found) begin
          grant_vec[grant_idx] = 1'b1;
          last_grant_next      = grant_idx;
          byte_idx_next        = 2'd0;
          tx_valid_next        = 1'b1;
          tx_data_next         = msg_byte(2'd0, grant_idx);
          state_next           = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (byte_idx == 2'd3) begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
          end else begin
            byte_idx_next = byte_idx + 2'd1;
            tx_data_next  = msg_byte(byte_idx + 2'd1, last_grant);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new press beats a same-cycle grant, so the button stays queued without an overrun.
  always_comb begin
    pending_next = pending;
    overrun_next = overrun_cnt;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (rise[i]) begin
        if (pending[i] && !grant_vec[i] && overrun_next != '1) begin
          overrun_next = overrun_next + CNT_W'(1);
        end
        pending_next[i] = 1'b1;
      end else if (grant_vec[i]) begin
        pending_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      btn_q       <= '0;
      last_grant  <= GW'(NUM_BTN - 1);
      byte_idx    <= 2'd0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      pending     <= '0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_next;
      btn_q       <= btn_db;
      last_grant  <= last_grant_next;
      byte_idx    <= byte_idx_next;
      tx_valid    <= tx_valid_next;
      tx_data     <= tx_data_next;
      pending     <= pending_next;
      overrun_cnt <= overrun_next;
    end
  end

endmodule

// File: tb/tb_button_msg_scheduler.sv
// Directed bench for button_msg_scheduler: a vector table for the single-press and
// backpressure flows, then hand-written sequences for arbitration, overrun and reset.
module tb_button_msg_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_db;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic [3:0] pending;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic       valid;
    logic [7:0] data;
    logic       bsy;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[19];

  button_msg_scheduler #(.NUM_BTN(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_db      (btn_db),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .busy        (busy),
    .pending     (pending),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic [3:0] btn, input logic rdy);
    @(negedge clk);
    btn_db   = btn;
    tx_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Expects 'B' on the outputs now, then walks the rest of the message with tx_ready high.
  task automatic readMessage(input logic [7:0] digit, input logic [3:0] btn);
    checkOutput("msg_b", {tx_valid, tx_data}, {1'b1, 8'h42});
    applyStimulus(btn, 1'b1);
    checkOutput("msg_digit", {tx_valid, tx_data}, {1'b1, 8'h30 + digit});
    applyStimulus(btn, 1'b1);
    checkOutput("msg_cr", {tx_valid, tx_data}, {1'b1, 8'h0D});
    applyStimulus(btn, 1'b1);
    checkOutput("msg_lf", {tx_valid, tx_data}, {1'b1, 8'h0A});
    applyStimulus(btn, 1'b1);
    checkOutput("msg_gap", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0100, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0100};
    vecs[2]  = '{4'b0100, 1'b1, 1'b1, 8'h42, 1'b1, 4'b0000};
    vecs[3]  = '{4'b0100, 1'b1, 1'b1, 8'h32, 1'b1, 4'b0000};
    vecs[4]  = '{4'b0000, 1'b1, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b1, 1'b1, 8'h0A, 1'b1, 4'b0000};
    vecs[6]  = '{4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};
    vecs[7]  = '{4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};
    vecs[8]  = '{4'b0100, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0100};
    vecs[9]  = '{4'b0100, 1'b1, 1'b1, 8'h42, 1'b1, 4'b0000};
    vecs[10] = '{4'b0000, 1'b1, 1'b1, 8'h32, 1'b1, 4'b0000};
    vecs[11] = '{4'b0000, 1'b1, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[12] = '{4'b0000, 1'b0, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[13] = '{4'b0000, 1'b0, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[14] = '{4'b0000, 1'b0, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[16] = '{4'b0000, 1'b0, 1'b1, 8'h0D, 1'b1, 4'b0000};
    vecs[17] = '{4'b0000, 1'b1, 1'b1, 8'h0A, 1'b1, 4'b0000};
    vecs[18] = '{4'b0000, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000};

    rst_n    = 1'b0;
    btn_db   = 4'b0000;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {17'd0, tx_valid, tx_data, busy, pending, overrun_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single press and backpressure vectors");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].valid});
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
      checkOutput($sformatf("vec%0d_pending", i), {28'd0, pending}, {28'd0, vecs[i].pend});
      checkOutput($sformatf("vec%0d_overrun", i), {24'd0, overrun_cnt}, 32'd0);
      if (vecs[i].valid)
        checkOutput($sformatf("vec%0d_data", i), {24'd0, tx_data}, {24'd0, vecs[i].data});
    end

    $display("[TB] simultaneous press");
    pulseReset();
    applyStimulus(4'b1011, 1'b1);
    checkOutput("sim_pending", {28'd0, pending}, 32'hB);
    applyStimulus(4'b1011, 1'b1);
    readMessage(8'd0, 4'b1011);
    applyStimulus(4'b1011, 1'b1);
    readMessage(8'd1, 4'b1011);
    applyStimulus(4'b1011, 1'b1);
    readMessage(8'd3, 4'b1011);
    checkOutput("sim_overrun", {24'd0, overrun_cnt}, 32'd0);

    $display("[TB] overrun while TX is stalled");
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4'b0011, 1'b0);
      applyStimulus(4'b0001, 1'b0);
    end
    checkOutput("ovr_pending", {28'd0, pending}, 32'h2);
    checkOutput("ovr_count", {24'd0, overrun_cnt}, 32'd2);
    checkOutput("ovr_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h42});
    readMessage(8'd0, 4'b0000);
    applyStimulus(4'b0000, 1'b1);
    readMessage(8'd1, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 1'b1);
      checkOutput("ovr_single_b1", {27'd0, tx_valid, pending}, 32'd0);
    end

    $display("[TB] re-press during own message");
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("own_b", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h42});
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("own_requeue", {28'd0, pending}, 32'h1);
    checkOutput("own_overrun", {24'd0, overrun_cnt}, 32'd2);
    applyStimulus(4'b0001, 1'b1);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("own_gap", {31'd0, tx_valid}, 32'd0);
    applyStimulus(4'b0001, 1'b1);
    readMessage(8'd0, 4'b0000);
    checkOutput("own_overrun_after", {24'd0, overrun_cnt}, 32'd2);

    $display("[TB] overrun saturation");
    applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b0);
    for (int p = 0; p < 301; p++) begin
      applyStimulus(4'b0011, 1'b0);
      applyStimulus(4'b0001, 1'b0);
    end
    checkOutput("sat_count", {24'd0, overrun_cnt}, 32'd255);
    checkOutput("sat_pending", {28'd0, pending}, 32'h2);

    $display("[TB] reset mid-message");
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rst_digit", {24'd0, tx_data}, 32'h30);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rst_cr", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h0D});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", {18'd0, tx_valid, busy, pending, overrun_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0000, 1'b1);
      checkOutput("rst_quiet", {26'd0, tx_valid, busy, pending}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
